// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the external-reference PLL supervisor.
// The phase counter is sized from the longest of the three per-channel intervals.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    READY     = 2'd3
  } pll_sup_state_t;

  localparam int STATE_W = 2;

  // Width needed to hold 0 .. max(a,b,c)-1, never less than one bit.
  function automatic int cycle_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_sup_channel.sv
// One supervised PLL channel: lock synchroniser, supervisor FSM, shared phase
// counter, saturating lock-loss counter and sticky timeout flag.
module pll_sup_channel
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH           = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cnt_clr,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 pll_ready,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] loss_cnt,
  output pll_sup_state_t       dbg_state
);

  localparam int CW = cycle_cnt_width(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0]        RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]        STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]        TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOSS_MAX    = {CNT_WIDTH{1'b1}};

  pll_sup_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           sync1, lk;
  logic           loss_evt, to_evt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1    <= 1'b0;
      lk       <= 1'b0;
      state    <= RESET;
      cnt      <= '0;
      timeout  <= 1'b0;
      loss_cnt <= '0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // A clear never swallows an event landing on the same edge.
      timeout <= cnt_clr ? to_evt : (timeout | to_evt);
      if (cnt_clr)
        loss_cnt <= CNT_WIDTH'(loss_evt);
      else if (loss_evt && (loss_cnt != LOSS_MAX))
        loss_cnt <= loss_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    to_evt    = 1'b0;
    if (!en) begin
      state_nxt = RESET;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RESET: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            state_nxt = RESET;
            cnt_nxt   = '0;
            to_evt    = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STABLE: begin
          // A dropout before qualification is a glitch, not a loss.
          if (!lk) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = READY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        READY: begin
          if (!lk) begin
            state_nxt = RESET;
            cnt_nxt   = '0;
            loss_evt  = 1'b1;
          end
        end
        default: begin
          state_nxt = RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign pll_rst   = (state == RESET);
  assign pll_ready = (state == READY);
  assign dbg_state = state;

endmodule

// File: rtl/ext_ref_pll_supervisor.sv
// Supervisor for NUM_PLLS external-reference PLLs on the 10 MHz refclk; each
// channel is independent, so this level only slices ports onto channel instances.
module ext_ref_pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_PLLS            = 2,
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH           = 8
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic [NUM_PLLS-1:0]           en_i,
  input  logic                          cnt_clr_i,
  input  logic [NUM_PLLS-1:0]           pll_locked_i,
  output logic [NUM_PLLS-1:0]           pll_rst_o,
  output logic [NUM_PLLS-1:0]           pll_ready_o,
  output logic [NUM_PLLS-1:0]           timeout_o,
  output logic [NUM_PLLS*CNT_WIDTH-1:0] lock_loss_cnt_o,
  output logic [NUM_PLLS*STATE_W-1:0]   dbg_state
);

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
    pll_sup_state_t ch_state;

    pll_sup_channel #(
      .RST_CYCLES         (RST_CYCLES),
      .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
      .CNT_WIDTH          (CNT_WIDTH)
    ) u_ch (
      .refclk    (refclk),
      .rst       (rst),
      .en        (en_i[i]),
      .cnt_clr   (cnt_clr_i),
      .pll_locked(pll_locked_i[i]),
      .pll_rst   (pll_rst_o[i]),
      .pll_ready (pll_ready_o[i]),
      .timeout   (timeout_o[i]),
      .loss_cnt  (lock_loss_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .dbg_state (ch_state)
    );

    assign dbg_state[i*STATE_W +: STATE_W] = ch_state;
  end

endmodule

// File: tb/tb_ext_ref_pll_supervisor.sv
// Bench for ext_ref_pll_supervisor: directed latency/saturation/clear checks plus
// randomized traffic, all compared each cycle against a timestamp-based model.
module tb_ext_ref_pll_supervisor;

  localparam int NP   = 2;
  localparam int RSTC = 4;
  localparam int LSC  = 8;
  localparam int LTC  = 32;
  localparam int CWID = 2;
  localparam int LMAX = (1 << CWID) - 1;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RDY  = 3;

  // clock / reset
  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic                 rst = 1'b1;
  logic [NP-1:0]        en_i = '1;
  logic                 cnt_clr_i = 1'b0;
  logic [NP-1:0]        pll_locked_i = '0;
  logic [NP-1:0]        pll_rst_o;
  logic [NP-1:0]        pll_ready_o;
  logic [NP-1:0]        timeout_o;
  logic [NP*CWID-1:0]   lock_loss_cnt_o;
  logic [NP*2-1:0]      dbg_state;

  ext_ref_pll_supervisor #(
    .NUM_PLLS           (NP),
    .RST_CYCLES         (RSTC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .CNT_WIDTH          (CWID)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .en_i           (en_i),
    .cnt_clr_i      (cnt_clr_i),
    .pll_locked_i   (pll_locked_i),
    .pll_rst_o      (pll_rst_o),
    .pll_ready_o    (pll_ready_o),
    .timeout_o      (timeout_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .dbg_state      (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // behavioural model: phase plus the cycle at which the phase was entered
  int m_ph[NP];
  int m_start[NP];
  int m_loss[NP];
  bit m_to[NP];
  bit m_d1[NP];
  bit m_d2[NP];

  always @(posedge refclk) begin
    logic [NP-1:0]      e_rst, e_rdy, e_to;
    logic [NP*CWID-1:0] e_cnt;
    cyc++;
    for (int ch = 0; ch < NP; ch++) begin
      if (rst) begin
        m_ph[ch] = PH_RST; m_start[ch] = cyc; m_loss[ch] = 0; m_to[ch] = 0;
        m_d1[ch] = 0; m_d2[ch] = 0;
      end else begin
        bit lk, lev, tev;
        int el;
        lk = m_d2[ch];
        m_d2[ch] = m_d1[ch];
        m_d1[ch] = pll_locked_i[ch];
        el  = cyc - m_start[ch];
        lev = 0; tev = 0;
        if (!en_i[ch]) begin
          m_ph[ch] = PH_RST; m_start[ch] = cyc;
        end else if (m_ph[ch] == PH_RST) begin
          if (el >= RSTC) begin m_ph[ch] = PH_WAIT; m_start[ch] = cyc; end
        end else if (m_ph[ch] == PH_WAIT) begin
          if (lk) begin m_ph[ch] = PH_STAB; m_start[ch] = cyc; end
          else if (el >= LTC) begin m_ph[ch] = PH_RST; m_start[ch] = cyc; tev = 1; end
        end else if (m_ph[ch] == PH_STAB) begin
          if (!lk) begin m_ph[ch] = PH_WAIT; m_start[ch] = cyc; end
          else if (el >= LSC) begin m_ph[ch] = PH_RDY; m_start[ch] = cyc; end
        end else begin
          if (!lk) begin m_ph[ch] = PH_RST; m_start[ch] = cyc; lev = 1; end
        end
        if (cnt_clr_i) begin
          m_loss[ch] = lev;
          m_to[ch]   = tev;
        end else begin
          if (lev && m_loss[ch] < LMAX) m_loss[ch]++;
          m_to[ch] = m_to[ch] | tev;
        end
      end
    end
    #1;
    for (int ch = 0; ch < NP; ch++) begin
      e_rst[ch] = (m_ph[ch] == PH_RST);
      e_rdy[ch] = (m_ph[ch] == PH_RDY);
      e_to[ch]  = m_to[ch];
      e_cnt[ch*CWID +: CWID] = CWID'(m_loss[ch]);
    end
    chk("model_pll_rst",  32'(pll_rst_o),       32'(e_rst));
    chk("model_ready",    32'(pll_ready_o),     32'(e_rdy));
    chk("model_timeout",  32'(timeout_o),       32'(e_to));
    chk("model_loss_cnt", 32'(lock_loss_cnt_o), 32'(e_cnt));
  end

  // driver helpers: inputs change on negedges, directed checks land just after posedges
  task automatic wait_edges(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic neg();
    @(negedge refclk);
  endtask

  function automatic logic [CWID-1:0] cnt0();
    return lock_loss_cnt_o[CWID-1:0];
  endfunction

  initial begin
    // 1: reset, both enabled, no lock
    rst = 1'b1; en_i = 2'b11; pll_locked_i = 2'b00; cnt_clr_i = 1'b0;
    repeat (3) neg();
    chk("rst_pll_rst",  32'(pll_rst_o), 32'h3);
    chk("rst_ready",    32'(pll_ready_o), 32'h0);
    chk("rst_timeout",  32'(timeout_o), 32'h0);
    chk("rst_loss_cnt", 32'(lock_loss_cnt_o), 32'h0);
    rst = 1'b0;
    wait_edges(3);
    chk("rstpulse_hold", 32'(pll_rst_o), 32'h3);
    wait_edges(1);
    chk("rstpulse_release", 32'(pll_rst_o), 32'h0);

    // 5: no lock -> timeout after LTC wait cycles, then a fresh reset pulse
    wait_edges(LTC - 1);
    chk("timeout_early", 32'(timeout_o), 32'h0);
    wait_edges(1);
    chk("timeout_set", 32'(timeout_o), 32'h3);
    chk("timeout_retry_rst", 32'(pll_rst_o), 32'h3);
    wait_edges(RSTC - 1);
    chk("retry_rst_hold", 32'(pll_rst_o), 32'h3);
    wait_edges(1);
    chk("retry_rst_release", 32'(pll_rst_o), 32'h0);
    neg(); cnt_clr_i = 1'b1;
    wait_edges(1);
    chk("clr_timeout", 32'(timeout_o), 32'h0);
    neg(); cnt_clr_i = 1'b0;

    // 3 and 2: glitch during qualification, then ready LSC+3 edges after re-rise
    rst = 1'b1;
    repeat (2) neg();
    rst = 1'b0;
    wait_edges(RSTC);
    neg(); pll_locked_i[0] = 1'b1;
    wait_edges(5);
    neg(); pll_locked_i[0] = 1'b0;
    wait_edges(1);
    neg(); pll_locked_i[0] = 1'b1;
    wait_edges(LSC + 2);
    chk("glitch_not_ready", 32'(pll_ready_o[0]), 32'h0);
    wait_edges(1);
    chk("glitch_ready", 32'(pll_ready_o[0]), 32'h1);
    chk("glitch_ch1_idle", 32'(pll_ready_o[1]), 32'h0);
    chk("glitch_no_loss", 32'(cnt0()), 32'h0);

    // 4: repeated losses, counter saturates at 3
    for (int k = 1; k <= 4; k++) begin
      neg(); pll_locked_i[0] = 1'b0;
      wait_edges(2);
      chk("loss_ready_held", 32'(pll_ready_o[0]), 32'h1);
      wait_edges(1);
      chk("loss_ready_drop", 32'(pll_ready_o[0]), 32'h0);
      chk("loss_rst_rise", 32'(pll_rst_o[0]), 32'h1);
      chk("loss_count", 32'(cnt0()), 32'((k > LMAX) ? LMAX : k));
      wait_edges(RSTC - 1);
      chk("loss_rst_hold", 32'(pll_rst_o[0]), 32'h1);
      wait_edges(1);
      chk("loss_rst_release", 32'(pll_rst_o[0]), 32'h0);
      neg(); pll_locked_i[0] = 1'b1;
      wait_edges(LSC + 2);
      chk("relock_not_ready", 32'(pll_ready_o[0]), 32'h0);
      wait_edges(1);
      chk("relock_ready", 32'(pll_ready_o[0]), 32'h1);
    end

    // 6: clear on the same edge as a loss keeps that loss
    neg(); pll_locked_i[0] = 1'b0;
    wait_edges(2);
    neg(); cnt_clr_i = 1'b1;
    wait_edges(1);
    chk("clr_coincident_loss", 32'(cnt0()), 32'h1);
    chk("clr_timeout_ch0", 32'(timeout_o[0]), 32'h0);
    neg(); cnt_clr_i = 1'b0; pll_locked_i[0] = 1'b1;
    begin
      int n = 0;
      while (pll_ready_o[0] !== 1'b1 && n < 60) begin
        wait_edges(1);
        n++;
      end
      chk("clr_relock_ready", 32'(pll_ready_o[0]), 32'h1);
    end
    neg(); en_i[0] = 1'b0;
    wait_edges(1);
    chk("disable_ready", 32'(pll_ready_o[0]), 32'h0);
    chk("disable_rst", 32'(pll_rst_o[0]), 32'h1);
    chk("disable_no_loss", 32'(cnt0()), 32'h1);
    neg(); en_i[0] = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      neg();
      cnt_clr_i = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 1499) == 0);
      for (int ch = 0; ch < NP; ch++) begin
        if ($urandom_range(0, 14) == 0)  pll_locked_i[ch] = ~pll_locked_i[ch];
        if ($urandom_range(0, 299) == 0) en_i[ch] = ~en_i[ch];
      end
    end
    neg();
    cnt_clr_i = 1'b0;
    rst = 1'b0;
    wait_edges(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
